ide_pio_sequencer: RTL
======================

IDE_PIO_SEQUENCER -- requirements
Module: ide_pio_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, IORDY wait limit in clocks; used only with IDE_TIMEOUT_EN, range 1..255.
REQ-002 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ide_access, input, 1, high when the current bus address decodes to the IDE register window.
REQ-005 SHALL have ports AS_n, UDS_n and LDS_n, input, 1 each, 68000 address and data strobes, active-low.
REQ-006 SHALL have port RW, input, 1, 1=read, 0=write.
REQ-007 SHALL have port IORDY, input, 1, asynchronous drive ready.
REQ-008 SHALL have port mode_wr, input, 1, one-clock strobe that loads mode_data.
REQ-009 SHALL have port mode_data, input, 3, requested PIO mode.
REQ-010 SHALL have ports IOR_n and IOW_n, output, 1 each, drive strobes, active-low.
REQ-011 SHALL have port DTACK, output, 1, active-high cycle acknowledge to the bus glue.
REQ-012 SHALL have port IDEBUF_OE, output, 1, active-low data buffer enable.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port timeout_flag, output, 1, sticky IORDY timeout indication.

Function
REQ-015 SHALL synchronise IORDY through two flops (iordy_s); all IORDY decisions use iordy_s.
REQ-016 SHALL hold a 3-bit mode register; mode_data values above 4 SHALL be stored as 4.
REQ-017 SHALL use this timing table, in clocks as setup/active/recovery: mode0 2/5/4, mode1 1/4/3, mode2 1/3/2, mode3 1/2/1, mode4 0/2/1.
REQ-018 SHALL latch the three counts on the IDLE exit edge; mode_wr during a cycle SHALL affect only the next cycle.
REQ-019 SHALL implement states IDLE, SETUP, STROBE, WAIT_RDY, ACK and RECOVER, each timed state lasting exactly its count in clocks.
REQ-020 IDLE: SHALL move on ide_access && !AS_n && (!UDS_n || !LDS_n) to SETUP, or directly to STROBE when setup=0.
REQ-021 SETUP: SHALL keep both strobes high, then move to STROBE.
REQ-022 STROBE: SHALL drive IOR_n=!RW and IOW_n=RW; at the end of the count SHALL move to ACK if iordy_s=1, else to WAIT_RDY.
REQ-023 WAIT_RDY: SHALL keep the strobe asserted and move to ACK on the first clock with iordy_s=1.
REQ-024 ACK: SHALL assert DTACK; on reads SHALL keep IOR_n low; on writes SHALL drive IOW_n high from ACK entry to give drive data hold; SHALL stay until AS_n=1.
REQ-025 RECOVER: SHALL deassert both strobes and DTACK, count recovery, then return to IDLE; a new request during RECOVER SHALL wait.
REQ-026 SHALL go to RECOVER on AS_n=1 in any of SETUP, STROBE or WAIT_RDY (abort), deasserting the strobes on the next edge, with DTACK never asserted.
REQ-027 SHALL assert IDEBUF_OE=0 in SETUP through ACK and keep it 1 otherwise.
REQ-028 SHALL never assert IOR_n and IOW_n low simultaneously.

Reset
REQ-029 RESET_n low SHALL force IDLE, mode=0, IOR_n=1, IOW_n=1, DTACK=0, IDEBUF_OE=1, busy=0, timeout_flag=0 and clear the counters and synchronisers.
REQ-030 Reset asserted mid-cycle SHALL take effect immediately, without waiting for a clock.

Configuration
REQ-031 Macro IDE_TIMEOUT_EN defined: an 8-bit counter SHALL run in WAIT_RDY; on reaching TIMEOUT_CYCLES with iordy_s=0 the block SHALL move to ACK and set timeout_flag, which clears only on mode_wr or reset.
REQ-032 Macro IDE_TIMEOUT_EN undefined: WAIT_RDY SHALL wait indefinitely, and timeout_flag SHALL be tied to 0.

Verification
REQ-033 Reset, mode0 read, IORDY=1: IOR_n low 2 clocks after the strobe qualifies, held through DTACK; DTACK asserts 7 clocks after qualify; recovery lasts 4 clocks after AS_n rises.
REQ-034 mode_wr with mode_data=4, then a write: IOW_n low on the first edge after qualify for 2 clocks; IOW_n high as DTACK asserts.
REQ-035 mode_data=7: the stored mode reads back as mode4 timing, identical to REQ-034.
REQ-036 mode2 read, IORDY low for 10 clocks during STROBE: IOR_n extended, DTACK asserts 2-3 clocks after IORDY rises (synchroniser latency).
REQ-037 AS_n rises in STROBE: strobe deasserts next edge, DTACK stays 0, busy falls after the recovery count.
REQ-038 With IDE_TIMEOUT_EN and IORDY held 0: DTACK at TIMEOUT_CYCLES=255 clocks into WAIT_RDY, timeout_flag=1, then cleared by mode_wr; without the macro: no DTACK and timeout_flag=0.

Source files
------------

// File: rtl/ide_pio_sequencer.sv
// ide_pio_sequencer -- 68000-bus to IDE PIO strobe sequencer.
//
// A 68000 access to the IDE register window is stretched into an ATA PIO cycle:
// address setup, IOR_n/IOW_n active pulse (extended by IORDY), DTACK back to
// the bus glue, then a recovery gap before the next cycle may start. Timing
// comes from a 3-bit PIO mode register (modes 0..4, larger values clamp to 4).
//
// Ports
//   CLK, RESET_n        clock (rising edge) and asynchronous active-low reset
//   ide_access          current address decodes to the IDE window
//   AS_n, UDS_n, LDS_n  68000 address / data strobes, active-low
//   RW                  1 = read, 0 = write
//   IORDY               drive ready, asynchronous (synchronised internally)
//   mode_wr, mode_data  one-clock strobe loading the requested PIO mode
//   IOR_n, IOW_n        drive read / write strobes, active-low
//   DTACK               active-high cycle acknowledge
//   IDEBUF_OE           data buffer enable, active-low
//   busy                sequencer not idle
//   timeout_flag        sticky IORDY timeout indication
//
// Configuration
//   IDE_TIMEOUT_EN  when defined, WAIT_RDY gives up after TIMEOUT_CYCLES clocks,
//                   completes the cycle and sets timeout_flag (cleared by
//                   mode_wr or reset). When undefined WAIT_RDY waits forever
//                   and timeout_flag is tied low.

module ide_pio_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       ide_access,
    input  logic       AS_n,
    input  logic       UDS_n,
    input  logic       LDS_n,
    input  logic       RW,
    input  logic       IORDY,
    input  logic       mode_wr,
    input  logic [2:0] mode_data,
    output logic       IOR_n,
    output logic       IOW_n,
    output logic       DTACK,
    output logic       IDEBUF_OE,
    output logic       busy,
    output logic       timeout_flag
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWaitRdy,
        StAck,
        StRecover
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] active_q, active_d;
    logic [2:0] recov_q, recov_d;
    logic       rw_q, rw_d;
    logic [2:0] mode_q;
    logic       iordy_m, iordy_s;
    logic       request;

    logic [1:0] tbl_setup;
    logic [2:0] tbl_active;
    logic [2:0] tbl_recov;

    logic ior_n_q, ior_n_d;
    logic iow_n_q, iow_n_d;
    logic dtack_q, dtack_d;
    logic oe_n_q, oe_n_d;
    logic busy_q, busy_d;

`ifdef IDE_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_q, tmo_d;
    logic       tflag_q, tflag_d;
`endif

    assign request = ide_access && !AS_n && (!UDS_n || !LDS_n);

    // Two-flop synchroniser; nothing downstream looks at raw IORDY.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            iordy_m <= 1'b0;
            iordy_s <= 1'b0;
        end else begin
            iordy_m <= IORDY;
            iordy_s <= iordy_m;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            mode_q <= 3'd0;
        end else if (mode_wr) begin
            mode_q <= (mode_data > 3'd4) ? 3'd4 : mode_data;
        end
    end

    // PIO timing table: setup / active / recovery in clocks.
    always_comb begin
        tbl_setup  = 2'd2;
        tbl_active = 3'd5;
        tbl_recov  = 3'd4;
        case (mode_q)
            3'd1: begin tbl_setup = 2'd1; tbl_active = 3'd4; tbl_recov = 3'd3; end
            3'd2: begin tbl_setup = 2'd1; tbl_active = 3'd3; tbl_recov = 3'd2; end
            3'd3: begin tbl_setup = 2'd1; tbl_active = 3'd2; tbl_recov = 3'd1; end
            3'd4: begin tbl_setup = 2'd0; tbl_active = 3'd2; tbl_recov = 3'd1; end
            default: ;
        endcase
    end

    // Each timed state is entered with cnt = count-1 and leaves when cnt hits 0,
    // so it lasts exactly its count in clocks.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        recov_d  = recov_q;
        rw_d     = rw_q;
`ifdef IDE_TIMEOUT_EN
        tmo_d    = tmo_q;
        tflag_d  = mode_wr ? 1'b0 : tflag_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (request) begin
                    // Counts are frozen here so a mode_wr mid-cycle only
                    // affects the following cycle.
                    active_d = tbl_active;
                    recov_d  = tbl_recov;
                    rw_d     = RW;
                    if (tbl_setup == 2'd0) begin
                        state_d = StStrobe;
                        cnt_d   = tbl_active - 3'd1;
                    end else begin
                        state_d = StSetup;
                        cnt_d   = {1'b0, tbl_setup} - 3'd1;
                    end
                end
            end
            StSetup: begin
                if (AS_n) begin
                    state_d = StRecover;
                    cnt_d   = recov_q - 3'd1;
                end else if (cnt_q == 3'd0) begin
                    state_d = StStrobe;
                    cnt_d   = active_q - 3'd1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StStrobe: begin
                if (AS_n) begin
                    state_d = StRecover;
                    cnt_d   = recov_q - 3'd1;
                end else if (cnt_q == 3'd0) begin
                    if (iordy_s) begin
                        state_d = StAck;
                    end else begin
                        state_d = StWaitRdy;
`ifdef IDE_TIMEOUT_EN
                        tmo_d   = 8'd0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWaitRdy: begin
                if (AS_n) begin
                    state_d = StRecover;
                    cnt_d   = recov_q - 3'd1;
                end else if (iordy_s) begin
                    state_d = StAck;
                end
`ifdef IDE_TIMEOUT_EN
                else if (tmo_q == TmoLast) begin
                    state_d = StAck;
                    tflag_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            StAck: begin
                if (AS_n) begin
                    state_d = StRecover;
                    cnt_d   = recov_q - 3'd1;
                end
            end
            StRecover: begin
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so the drive strobes are
    // glitch-free flop outputs that change on the same edge as the state.
    always_comb begin
        ior_n_d = 1'b1;
        iow_n_d = 1'b1;
        dtack_d = 1'b0;
        oe_n_d  = 1'b1;
        busy_d  = (state_d != StIdle);
        unique case (state_d)
            StSetup: oe_n_d = 1'b0;
            StStrobe, StWaitRdy: begin
                oe_n_d  = 1'b0;
                ior_n_d = !rw_d;
                iow_n_d = rw_d;
            end
            StAck: begin
                // Reads keep IOR_n low while the CPU latches data; writes
                // release IOW_n here so the data stays valid past the edge.
                oe_n_d  = 1'b0;
                dtack_d = 1'b1;
                ior_n_d = !rw_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            active_q <= 3'd0;
            recov_q  <= 3'd0;
            rw_q     <= 1'b1;
            ior_n_q  <= 1'b1;
            iow_n_q  <= 1'b1;
            dtack_q  <= 1'b0;
            oe_n_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            recov_q  <= recov_d;
            rw_q     <= rw_d;
            ior_n_q  <= ior_n_d;
            iow_n_q  <= iow_n_d;
            dtack_q  <= dtack_d;
            oe_n_q   <= oe_n_d;
            busy_q   <= busy_d;
        end
    end

`ifdef IDE_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            tmo_q   <= 8'd0;
            tflag_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            tflag_q <= tflag_d;
        end
    end

    assign timeout_flag = tflag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign IOR_n     = ior_n_q;
    assign IOW_n     = iow_n_q;
    assign DTACK     = dtack_q;
    assign IDEBUF_OE = oe_n_q;
    assign busy      = busy_q;

endmodule
